axi_burst_ctrl: RTL and testbench

AXI_BURST_CTRL -- requirements
Module: axi_burst_ctrl

---
 rtl/axi_burst_ctrl_if.sv | 57 +++++
 rtl/axi_burst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_axi_burst_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_ctrl_if.sv
// Request/AXI bundle for axi_burst_ctrl.
//   Request side : req, ad, wblock, wword, wstrb -> ready, task_finish, rblock, rword
//   AXI read     : araddr, arlen, arvalid / arready, rdata, rlast, rvalid / rready
//   AXI write    : awaddr, awlen, awvalid / awready, wdata, axi_wstrb, wlast, wvalid / wready,
//                  bvalid / bready
// modport master: the controller (it is the AXI master and serves the requester).
// modport slave : the environment (requester plus AXI memory).
interface axi_burst_ctrl_if #(
  parameter int BLOCK_WORDS = 4
);
  logic [2:0]               req;
  logic [31:0]              ad;
  logic [32*BLOCK_WORDS-1:0] wblock;
  logic [31:0]              wword;
  logic [3:0]               wstrb;
  logic                     ready;
  logic                     task_finish;
  logic [32*BLOCK_WORDS-1:0] rblock;
  logic [31:0]              rword;

  logic [31:0]              araddr;
  logic [7:0]               arlen;
  logic                     arvalid;
  logic                     arready;
  logic [31:0]              rdata;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  logic [31:0]              awaddr;
  logic [7:0]               awlen;
  logic                     awvalid;
  logic                     awready;
  logic [31:0]              wdata;
  logic [3:0]               axi_wstrb;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;
  logic                     bvalid;
  logic                     bready;

  modport master (
    input  req, ad, wblock, wword, wstrb,
    input  arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output ready, task_finish, rblock, rword,
    output araddr, arlen, arvalid, rready,
    output awaddr, awlen, awvalid, wdata, axi_wstrb, wlast, wvalid, bready
  );

  modport slave (
    output req, ad, wblock, wword, wstrb,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid,
    input  ready, task_finish, rblock, rword,
    input  araddr, arlen, arvalid, rready,
    input  awaddr, awlen, awvalid, wdata, axi_wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/axi_burst_ctrl.sv
// axi_burst_ctrl: turns word/block load and store requests into single AXI
// INCR bursts of 4-byte beats, one transaction in flight at a time.
// Ports:
//   clk  : clock, posedge
//   rstn : synchronous active-low reset; all outputs forced to 0
//   bus  : axi_burst_ctrl_if.master (request side + AXI read/write channels)
// BLOCK_WORDS is expected to be a power of two (block alignment is a mask).
module axi_burst_ctrl #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  axi_burst_ctrl_if.master bus
);
  localparam int BW_W = (BLOCK_WORDS < 2) ? 2 : $clog2(BLOCK_WORDS) + 1;
  localparam int BLK_BITS = 32 * BLOCK_WORDS;
  localparam logic [31:0]     BLK_MASK = 32'(4 * BLOCK_WORDS - 1);
  localparam logic [BW_W-1:0] BLK_CNT  = BW_W'(BLOCK_WORDS);
  localparam logic [BW_W-1:0] BLK_LAST = BW_W'(BLOCK_WORDS - 1);
  localparam logic [7:0]      BLK_LEN  = 8'(BLOCK_WORDS - 1);

  localparam logic [2:0] REQ_LW = 3'd1, REQ_LB = 3'd2, REQ_WW = 3'd3, REQ_WB = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                state_q;
  logic                  blk_q;
  logic [BW_W-1:0]       beat_q;
  logic [BW_W-1:0]       len_q;
  logic [BLK_BITS-1:0]   wblock_q;
  logic [31:0]           wword_q;
  logic [3:0]            wstrb_q;

  logic                  ready_q, task_finish_q;
  logic [BLK_BITS-1:0]   rblock_q;
  logic [31:0]           rword_q;
  logic [31:0]           araddr_q, awaddr_q;
  logic [7:0]            arlen_q, awlen_q;
  logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [31:0]           wdata_q;
  logic [3:0]            axi_wstrb_q;

  // Request decode on the live inputs; only sampled in IDLE.
  logic            is_load_d, is_store_d, is_blk_d;
  logic [31:0]     addr_d;
  logic [BW_W-1:0] nxt_beat_d;

  always_comb begin
    is_load_d  = (bus.req == REQ_LW) || (bus.req == REQ_LB);
    is_store_d = (bus.req == REQ_WW) || (bus.req == REQ_WB);
    is_blk_d   = (bus.req == REQ_LB) || (bus.req == REQ_WB);
    addr_d     = is_blk_d ? (bus.ad & ~BLK_MASK) : bus.ad;
    nxt_beat_d = beat_q + BW_W'(1);
  end

  function automatic logic [31:0] word_of(input logic [BLK_BITS-1:0] blk, input int idx);
    return blk[32*idx +: 32];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      blk_q         <= 1'b0;
      beat_q        <= '0;
      len_q         <= '0;
      wblock_q      <= '0;
      wword_q       <= '0;
      wstrb_q       <= '0;
      ready_q       <= 1'b0;
      task_finish_q <= 1'b0;
      rblock_q      <= '0;
      rword_q       <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      wdata_q       <= '0;
      axi_wstrb_q   <= '0;
      wlast_q       <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      ready_q       <= 1'b0;
      task_finish_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (is_load_d || is_store_d) begin
            ready_q  <= 1'b1;
            blk_q    <= is_blk_d;
            len_q    <= is_blk_d ? BLK_LAST : '0;
            wblock_q <= bus.wblock;
            wword_q  <= bus.wword;
            wstrb_q  <= bus.wstrb;
            if (is_load_d) begin
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= addr_d;
              arlen_q   <= is_blk_d ? BLK_LEN : 8'd0;
            end else begin
              state_q   <= S_AW;
              awvalid_q <= 1'b1;
              awaddr_q  <= addr_d;
              awlen_q   <= is_blk_d ? BLK_LEN : 8'd0;
            end
          end
        end
        S_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (bus.rvalid) begin
            // Beats past the block are dropped; counter saturates so it never wraps back.
            if (beat_q < BLK_CNT) begin
              rblock_q[32*int'(beat_q) +: 32] <= bus.rdata;
              beat_q <= nxt_beat_d;
            end
            if (beat_q == '0) rword_q <= bus.rdata;
            if (bus.rlast) begin
              rready_q <= 1'b0;
              state_q  <= S_DONE;
            end
          end
        end
        S_AW: begin
          if (bus.awready) begin
            awvalid_q   <= 1'b0;
            beat_q      <= '0;
            wvalid_q    <= 1'b1;
            wdata_q     <= blk_q ? word_of(wblock_q, 0) : wword_q;
            axi_wstrb_q <= blk_q ? 4'hF : wstrb_q;
            wlast_q     <= (len_q == '0);
            state_q     <= S_W;
          end
        end
        S_W: begin
          if (bus.wready) begin
            if (wlast_q) begin
              wvalid_q    <= 1'b0;
              wlast_q     <= 1'b0;
              wdata_q     <= '0;
              axi_wstrb_q <= '0;
              bready_q    <= 1'b1;
              state_q     <= S_B;
            end else begin
              // Preload the next beat so wdata is a register, stable through stalls.
              beat_q  <= nxt_beat_d;
              wdata_q <= word_of(wblock_q, int'(nxt_beat_d));
              wlast_q <= (nxt_beat_d == len_q);
            end
          end
        end
        S_B: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // task_finish is registered, so it appears the cycle after DONE.
          task_finish_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.task_finish = task_finish_q;
  assign bus.rblock      = rblock_q;
  assign bus.rword       = rword_q;
  assign bus.araddr      = araddr_q;
  assign bus.arlen       = arlen_q;
  assign bus.arvalid     = arvalid_q;
  assign bus.rready      = rready_q;
  assign bus.awaddr      = awaddr_q;
  assign bus.awlen       = awlen_q;
  assign bus.awvalid     = awvalid_q;
  assign bus.wdata       = wdata_q;
  assign bus.axi_wstrb   = axi_wstrb_q;
  assign bus.wlast       = wlast_q;
  assign bus.wvalid      = wvalid_q;
  assign bus.bready      = bready_q;
endmodule

// File: tb/tb_axi_burst_ctrl.sv
// Directed bench for axi_burst_ctrl (BLOCK_WORDS=4) with hand-computed expectations.
module tb_axi_burst_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  axi_burst_ctrl_if #(.BLOCK_WORDS(4)) bif ();
  axi_burst_ctrl #(.BLOCK_WORDS(4)) dut (.clk(clk), .rstn(rstn), .bus(bif.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, bif.ready, 0);
    chk({tag, ".finish"}, bif.task_finish, 0);
    chk({tag, ".arvalid"}, bif.arvalid, 0);
    chk({tag, ".araddr"}, bif.araddr, 0);
    chk({tag, ".rready"}, bif.rready, 0);
    chk({tag, ".awvalid"}, bif.awvalid, 0);
    chk({tag, ".wvalid"}, bif.wvalid, 0);
    chk({tag, ".wlast"}, bif.wlast, 0);
    chk({tag, ".bready"}, bif.bready, 0);
    chk({tag, ".rblock"}, bif.rblock, 0);
    chk({tag, ".rword"}, bif.rword, 0);
  endtask

  logic [127:0] wb;

  initial begin
    bif.req = 3'd0; bif.ad = '0; bif.wblock = '0; bif.wword = '0; bif.wstrb = '0;
    bif.arready = 0; bif.rdata = '0; bif.rlast = 0; bif.rvalid = 0;
    bif.awready = 0; bif.wready = 0; bif.bvalid = 0;

    tick(); tick();
    chk_all_zero("rst");
    rstn = 1'b1;

    // Reserved code 5 behaves like NONE.
    bif.req = 3'd5; bif.ad = 32'h10;
    tick();
    chk("nop.ready", bif.ready, 0);
    chk("nop.arvalid", bif.arvalid, 0);
    chk("nop.awvalid", bif.awvalid, 0);
    bif.req = 3'd0;
    tick();

    // LOAD_WORD 0x1C, always-ready slave: ready cycle 1, finish cycle 4.
    bif.req = 3'd1; bif.ad = 32'h1C;
    bif.arready = 1; bif.rvalid = 1; bif.rlast = 1; bif.rdata = 32'hDEADBEEF;
    tick();
    chk("lw.ready", bif.ready, 1);
    chk("lw.arvalid", bif.arvalid, 1);
    chk("lw.araddr", bif.araddr, 32'h1C);
    chk("lw.arlen", bif.arlen, 0);
    bif.req = 3'd0;
    tick();
    chk("lw.ready_pulse", bif.ready, 0);
    chk("lw.rready", bif.rready, 1);
    chk("lw.arvalid_drop", bif.arvalid, 0);
    tick();
    chk("lw.fin_early", bif.task_finish, 0);
    bif.rvalid = 0; bif.rlast = 0;
    tick();
    chk("lw.finish", bif.task_finish, 1);
    chk("lw.rword", bif.rword, 32'hDEADBEEF);
    tick();
    chk("lw.fin_pulse", bif.task_finish, 0);

    // LOAD_BLOCK 0x1234 -> aligned 0x1230, 4 beats.
    bif.req = 3'd2; bif.ad = 32'h1234;
    tick();
    chk("lb.ready", bif.ready, 1);
    chk("lb.araddr", bif.araddr, 32'h1230);
    chk("lb.arlen", bif.arlen, 3);
    bif.req = 3'd0;
    tick();
    chk("lb.rready", bif.rready, 1);
    for (int i = 0; i < 4; i++) begin
      bif.rvalid = 1; bif.rdata = 32'(i); bif.rlast = (i == 3);
      tick();
      chk("lb.fin_mid", bif.task_finish, 0);
    end
    bif.rvalid = 0; bif.rlast = 0;
    tick();
    chk("lb.finish", bif.task_finish, 1);
    chk("lb.rblock", bif.rblock, 128'h00000003_00000002_00000001_00000000);
    chk("lb.rword", bif.rword, 32'h0);
    tick();

    // WRITE_BLOCK with 2 stall cycles per beat.
    wb = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    bif.req = 3'd4; bif.ad = 32'h1238; bif.wblock = wb;
    bif.awready = 1; bif.wready = 0;
    tick();
    chk("wb.ready", bif.ready, 1);
    chk("wb.awvalid", bif.awvalid, 1);
    chk("wb.awaddr", bif.awaddr, 32'h1230);
    chk("wb.awlen", bif.awlen, 3);
    bif.req = 3'd0; bif.wblock = '0;
    tick();
    bif.awready = 0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        chk("wb.wvalid", bif.wvalid, 1);
        chk("wb.wdata", bif.wdata, wb[32*b +: 32]);
        chk("wb.wlast", bif.wlast, (b == 3));
        chk("wb.wstrb", bif.axi_wstrb, 4'hF);
        if (s == 2) bif.wready = 1;
        tick();
        bif.wready = 0;
      end
    end
    chk("wb.wvalid_drop", bif.wvalid, 0);
    chk("wb.bready", bif.bready, 1);
    bif.bvalid = 1;
    tick();
    bif.bvalid = 0;
    chk("wb.bready_drop", bif.bready, 0);
    tick();
    chk("wb.finish", bif.task_finish, 1);
    chk("wb.rblock_held", bif.rblock, 128'h00000003_00000002_00000001_00000000);
    tick();

    // WRITE_WORD strobe 0x3, awready held off for 5 cycles of awvalid.
    bif.req = 3'd3; bif.ad = 32'h1235; bif.wword = 32'hCAFEF00D; bif.wstrb = 4'h3;
    tick();
    chk("ww.ready", bif.ready, 1);
    chk("ww.awaddr", bif.awaddr, 32'h1235);
    chk("ww.awlen", bif.awlen, 0);
    bif.req = 3'd0;
    for (int i = 0; i < 5; i++) begin
      chk("ww.awvalid_hold", bif.awvalid, 1);
      if (i == 4) bif.awready = 1;
      tick();
    end
    bif.awready = 0;
    chk("ww.awvalid_drop", bif.awvalid, 0);
    chk("ww.wvalid", bif.wvalid, 1);
    chk("ww.wdata", bif.wdata, 32'hCAFEF00D);
    chk("ww.wstrb", bif.axi_wstrb, 4'h3);
    chk("ww.wlast", bif.wlast, 1);
    bif.wready = 1;
    tick();
    bif.wready = 0;
    chk("ww.bready", bif.bready, 1);
    chk("ww.wvalid_drop", bif.wvalid, 0);
    bif.bvalid = 1;
    tick();
    bif.bvalid = 0;
    tick();
    chk("ww.finish", bif.task_finish, 1);
    tick();

    // Reset during read beat 2, then a clean LOAD_WORD.
    bif.req = 3'd2; bif.ad = 32'h40; bif.arready = 1;
    tick();
    bif.req = 3'd0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bif.rvalid = 1; bif.rdata = 32'h100 + 32'(i); bif.rlast = 0;
      tick();
    end
    bif.rdata = 32'h102; rstn = 1'b0;
    tick();
    chk_all_zero("rstmid");
    rstn = 1'b1; bif.rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid.no_finish", bif.task_finish, 0);
    end
    bif.req = 3'd1; bif.ad = 32'h8;
    bif.rvalid = 1; bif.rlast = 1; bif.rdata = 32'h55AA;
    tick();
    chk("post.ready", bif.ready, 1);
    chk("post.araddr", bif.araddr, 32'h8);
    bif.req = 3'd0;
    tick(); tick();
    bif.rvalid = 0; bif.rlast = 0;
    tick();
    chk("post.finish", bif.task_finish, 1);
    chk("post.rword", bif.rword, 32'h55AA);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
